edge_capture_in_pio: RTL and testbench
======================================

Name: edge_capture_in_pio

Overview:
- Avalon-MM slave input port. It is the read-direction counterpart of the team's output PIO registers.
- Samples external asynchronous inputs such as push-buttons or pattern-select switches, then synchronises and debounces them.
- Latches qualifying edges into a software-clearable capture register and raises a maskable interrupt to the Nios II.
- Sits on the system interconnect beside the output PIOs; software reads the debounced level or services edge interrupts.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 16, cycles a new synchronised level must hold before it is accepted (>=1).
- EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- read  in  1  read strobe (qualified by chipselect).
- write_n  in  1  active-low write strobe (qualified by chipselect).
- writedata  in  WIDTH  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  WIDTH  registered read data.
- irq  out  1  interrupt request, active high.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: sync stages, stable, stable_d, debounce counters, edgecapture, irqmask and readdata are all 0. irq is 0 in the cycle after reset is sampled.
- Register map:
  - addr 0: DATA. Debounced level (stable), read-only; writes ignored.
  - addr 1: reserved. Reads 0; writes ignored.
  - addr 2: IRQMASK. Read/write; bit i enables bit i of the interrupt.
  - addr 3: EDGECAPTURE. Read returns captured edges; a write clears every bit where writedata is 1 (write-1-to-clear); bits written 0 are unchanged.
- Write strobe: chipselect & ~write_n. No waitrequest; every access completes.
- Read path: readdata is updated on every edge where chipselect & read, from the register selected by address. Read latency is 1 cycle. readdata holds its value otherwise.
- Synchroniser: two flops per bit (s1 <= in_port, s2 <= s1).
- Debounce, independent per bit, with a counter width of ceil(log2(DEBOUNCE_CYCLES)), minimum 1:
  - s2 == stable: counter <= 0.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Otherwise: counter increments.
  - Any return of s2 to the stable value before expiry restarts the count.
  - DEBOUNCE_CYCLES=1: stable follows s2 with one cycle of delay.
- Latency: a clean level change that is first sampled at edge E0 appears on stable at edge E0+1+DEBOUNCE_CYCLES, which is readable on DATA from the following read.
- Edge detect:
  - stable_d <= stable every cycle.
  - rise = stable & ~stable_d; fall = ~stable & stable_d. EDGE_TYPE selects rise, fall or rise|fall.
  - edgecapture[i] <= 1 on a qualifying edge. It stays set until cleared by software.
- Simultaneous set and clear: if a qualifying edge and a W1C clear hit the same bit in the same cycle, the set wins and the bit remains 1.
- Interrupt: irq = |(edgecapture & irqmask), combinational from registers. It rises in the same cycle that the qualifying bit or mask bit becomes 1. It falls in the cycle after the clearing write or mask write.
- Power-up with inputs high: stable starts at 0, so an input held high through reset produces one rising edge DEBOUNCE_CYCLES+2 cycles after reset deasserts. Software clears EDGECAPTURE after init.
- Reset mid-operation: reset takes priority over any access or debounce in progress. Partial counts are discarded and all state returns to reset values.
- Widths: writedata bits above WIDTH do not exist. Registers are exactly WIDTH bits.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated):
- Reset, then read each address -> readdata=0 one cycle after each read; irq=0.
- Set in_port=4'b0001 held -> DATA reads 1 from edge E0+5 onward; EDGECAPTURE=4'b0001. With IRQMASK=0: irq=0. Write IRQMASK=4'b0001 -> irq=1 the same cycle the mask register updates.
- Glitch on bit 1: high for 3 cycles then low -> DATA bit1 stays 0; EDGECAPTURE bit1 stays 0. Then high for 4 or more cycles -> DATA bit1=1, capture bit1=1.
- With EDGECAPTURE=4'b0011, write addr3 with 4'b0001 -> EDGECAPTURE=4'b0010. With IRQMASK=4'b0001 -> irq falls the next cycle.
- Rising edge on bit 2 coinciding with a write of 4'b0100 to addr3 -> bit2 stays 1.
- EDGE_TYPE=2: bit 3 toggles 0->1->0 with clean holds -> capture set after each transition (clear it in between). With EDGE_TYPE=1 only the 1->0 transition sets it.

Source files
------------

// File: rtl/edge_capture_in_pio.sv
// edge_capture_in_pio
// Avalon-MM slave input port. External asynchronous inputs are synchronised
// through two flops, debounced per bit, and edges of the debounced level are
// latched into a write-1-to-clear capture register that drives a maskable
// interrupt.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   address     register select: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect  slave select
//   read        read strobe (qualified by chipselect)
//   write_n     active-low write strobe (qualified by chipselect)
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle latency
//   irq         interrupt request, |(edgecapture & irqmask)

module edge_capture_in_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] stable_dly_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] readdata_q, readdata_d;

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] rise, fall, qual_edge;
   logic [WIDTH-1:0] clr_mask;

   assign wr_en = chipselect & ~write_n;
   assign rd_en = chipselect & read;

   // Per-bit debounce: a differing synchronised level must persist for
   // DEBOUNCE_CYCLES consecutive samples; any return to the stable value
   // restarts the count from zero.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise = stable_q & ~stable_dly_q;
   assign fall = ~stable_q & stable_dly_q;

   always_comb begin
      if (EDGE_TYPE == 0) begin
         qual_edge = rise;
      end else if (EDGE_TYPE == 1) begin
         qual_edge = fall;
      end else begin
         qual_edge = rise | fall;
      end
   end

   // The set term is OR-ed after the clear so a coincident edge is never lost.
   assign clr_mask  = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;
   assign edgecap_d = (edgecap_q & ~clr_mask) | qual_edge;
   assign irqmask_d = (wr_en && address == ADDR_IRQMASK) ? writedata : irqmask_q;

   always_comb begin
      readdata_d = readdata_q;
      if (rd_en) begin
         case (address)
            ADDR_DATA:    readdata_d = stable_q;
            ADDR_IRQMASK: readdata_d = irqmask_q;
            ADDR_EDGECAP: readdata_d = edgecap_q;
            default:      readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         edgecap_q    <= '0;
         irqmask_q    <= '0;
         readdata_q   <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q         <= in_port;
         s2_q         <= s1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         edgecap_q    <= edgecap_d;
         irqmask_q    <= irqmask_d;
         readdata_q   <= readdata_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_edge_capture_in_pio.sv
module tb_edge_capture_in_pio;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] address;
   logic       chipselect;
   logic       read;
   logic       write_n;
   logic [3:0] writedata;
   logic [3:0] in_port;
   logic [3:0] rd0, rd1, rd2;
   logic       irq0, irq1, irq2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Rising-edge instance carries the main tests; the other two share the bus
   // and inputs and are used for the EDGE_TYPE comparison.
   edge_capture_in_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0));

   edge_capture_in_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd1), .irq(irq1));

   edge_capture_in_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd2), .irq(irq2));

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [3:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [3:0] r0,
                           output logic [3:0] r1, output logic [3:0] r2);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      tick(1);
      r0 = rd0;
      r1 = rd1;
      r2 = rd2;
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] r0, r1, r2;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      n_vec++;
      if (irq0 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_irq: got %b want 0", irq0);
      end
      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), r0, r1, r2);
         n_vec++;
         if (r0 !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_read addr%0d: got %b want 0000", a, r0);
         end
      end
   endtask

   task automatic test_level();
      logic [3:0] r0, r1, r2;
      in_port = 4'b0001;
      tick(5);                       // edges E0..E0+4
      read_reg(2'd0, r0, r1, r2);    // samples at E0+5, before stable updates
      n_vec++;
      if (r0 !== 4'b0000) begin
         n_err++;
         $display("FAIL level_early: got %b want 0000", r0);
      end
      read_reg(2'd0, r0, r1, r2);    // E0+6
      n_vec++;
      if (r0 !== 4'b0001) begin
         n_err++;
         $display("FAIL level_data: got %b want 0001", r0);
      end
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0001) begin
         n_err++;
         $display("FAIL level_capture: got %b want 0001", r0);
      end
      n_vec++;
      if (irq0 !== 1'b0) begin
         n_err++;
         $display("FAIL level_irq_masked: got %b want 0", irq0);
      end
      write_reg(2'd2, 4'b0001);
      n_vec++;
      if (irq0 !== 1'b1) begin
         n_err++;
         $display("FAIL level_irq_unmasked: got %b want 1", irq0);
      end
      read_reg(2'd2, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0001) begin
         n_err++;
         $display("FAIL irqmask_read: got %b want 0001", r0);
      end
   endtask

   task automatic test_glitch();
      logic [3:0] r0, r1, r2;
      in_port = 4'b0011;
      tick(3);
      in_port = 4'b0001;
      tick(10);
      read_reg(2'd0, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0001) begin
         n_err++;
         $display("FAIL glitch_data: got %b want 0001", r0);
      end
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0001) begin
         n_err++;
         $display("FAIL glitch_capture: got %b want 0001", r0);
      end
      in_port = 4'b0011;
      tick(8);
      read_reg(2'd0, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0011) begin
         n_err++;
         $display("FAIL held_data: got %b want 0011", r0);
      end
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0011) begin
         n_err++;
         $display("FAIL held_capture: got %b want 0011", r0);
      end
   endtask

   task automatic test_w1c();
      logic [3:0] r0, r1, r2;
      n_vec++;
      if (irq0 !== 1'b1) begin
         n_err++;
         $display("FAIL w1c_irq_before: got %b want 1", irq0);
      end
      write_reg(2'd3, 4'b0001);
      n_vec++;
      if (irq0 !== 1'b0) begin
         n_err++;
         $display("FAIL w1c_irq_after: got %b want 0", irq0);
      end
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0010) begin
         n_err++;
         $display("FAIL w1c_capture: got %b want 0010", r0);
      end
      // DATA and reserved ignore writes
      write_reg(2'd0, 4'b1100);
      write_reg(2'd1, 4'b1111);
      read_reg(2'd0, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0011) begin
         n_err++;
         $display("FAIL data_ro: got %b want 0011", r0);
      end
      read_reg(2'd1, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0000) begin
         n_err++;
         $display("FAIL reserved_read: got %b want 0000", r0);
      end
   endtask

   task automatic test_set_wins();
      logic [3:0] r0, r1, r2;
      in_port = 4'b0111;
      tick(6);                       // edges E0..E0+5
      write_reg(2'd3, 4'b0100);      // clear lands on E0+6 with the capture set
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0110) begin
         n_err++;
         $display("FAIL set_wins: got %b want 0110", r0);
      end
      write_reg(2'd3, 4'b0100);
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0010) begin
         n_err++;
         $display("FAIL clear_after: got %b want 0010", r0);
      end
   endtask

   task automatic test_edge_type();
      logic [3:0] r0, r1, r2;
      write_reg(2'd3, 4'b1111);
      in_port = 4'b1111;
      tick(10);
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b1000) begin
         n_err++;
         $display("FAIL rise_on_rise: got %b want 1000", r0);
      end
      n_vec++;
      if (r1 !== 4'b0000) begin
         n_err++;
         $display("FAIL fall_on_rise: got %b want 0000", r1);
      end
      n_vec++;
      if (r2 !== 4'b1000) begin
         n_err++;
         $display("FAIL any_on_rise: got %b want 1000", r2);
      end
      write_reg(2'd3, 4'b1111);
      in_port = 4'b0111;
      tick(10);
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0000) begin
         n_err++;
         $display("FAIL rise_on_fall: got %b want 0000", r0);
      end
      n_vec++;
      if (r1 !== 4'b1000) begin
         n_err++;
         $display("FAIL fall_on_fall: got %b want 1000", r1);
      end
      n_vec++;
      if (r2 !== 4'b1000) begin
         n_err++;
         $display("FAIL any_on_fall: got %b want 1000", r2);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] r0, r1, r2;
      in_port = 4'b0000;
      tick(3);                       // debounce of the falling level in progress
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      n_vec++;
      if (irq0 !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_irq: got %b want 0", irq0);
      end
      read_reg(2'd2, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_reset_mask: got %b want 0000", r0);
      end
      tick(10);
      read_reg(2'd3, r0, r1, r2);
      n_vec++;
      if (r0 !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_reset_capture: got %b want 0000", r0);
      end
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      #1;
      test_reset();
      test_level();
      test_glitch();
      test_w1c();
      test_set_wins();
      test_edge_type();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
